dual_wb_stage: RTL and testbench
================================

# dual_wb_stage

Two-lane writeback stage that collects execution results and drives the write ports of the dual register file (`regWrite1/2`, `destReg1/2`, `writeData1/2`). Each lane buffers accepted results in a small FIFO, retires one write per cycle, drops writes to r0, and keeps a per-lane pending-write scoreboard. The issue stage uses that scoreboard to block a second in-flight write to the same register. Lane 1 feeds register set 1 and lane 2 feeds register set 2; the lanes never interact.

## Interface
Parameters:
- `DATA_W`, 16, result/data width
- `REG_ADDR_W`, 4, register index width (16 registers)
- `DEPTH`, 2, FIFO entries per lane (power of two, ≥2)

Ports (x = 1, 2; one set per lane):
- `clk`  in  1  single clock; all state updates on posedge
- `reset`  in  1  asynchronous, active-low; clears all state immediately
- `wbStall`  in  1  shared; when high, no writeback retires this cycle
- `exValid`x  in  1  result valid from execute lane x
- `exReady`x  out  1  lane x can accept a result
- `exWrEn`x  in  1  result actually writes a register
- `exDest`x  in  REG_ADDR_W  destination register
- `exData`x  in  DATA_W  result value
- `issueValid`x  in  1  issue stage wants to dispatch a register-writing op to lane x
- `issueDest`x  in  REG_ADDR_W  its destination
- `issueReady`x  out  1  dispatch allowed (no WAW on lane x)
- `busy`x  out  16  pending-write mask, bit r = register r has a write in flight
- `regWrite`x  out  1  register-file write enable, registered
- `destReg`x  out  REG_ADDR_W  register-file write index, registered
- `writeData`x  out  DATA_W  register-file write data, registered

## Operation
- Accept: handshake = `exValid`x & `exReady`x at posedge. If `exWrEn`x=0 or `exDest`x=0, the result is accepted and discarded (no enqueue, no write).
- `exReady`x = reset high & (count < DEPTH). It depends only on the registered count, never on the same-cycle pop, so a full FIFO is not ready even if it pops that edge.
- Retire: each posedge with `wbStall`=0, the output register loads the FIFO head (pop), and `regWrite`x=1 for the following cycle. If nothing is available, or `wbStall`=1, `regWrite`x=0 next cycle. `destReg`/`writeData` hold their last value when `regWrite`=0.
- FIFO order is strict per lane. Simultaneous push and pop keeps count unchanged.
- Scoreboard:
  - set `busy`x[d] on edge where `issueValid`x & `issueReady`x & d≠0.
  - clear `busy`x[destReg] on the edge ending a cycle with `regWrite`x=1.
  - Set and clear of the same bit on the same edge: set wins.
  - `busy`x[0] is constantly 0.
- `issueReady`x = reset high & !(`busy`x[`issueDest`x]) | `issueDest`x==0. This is combinational from registered state.
- Reset (async, any time): FIFOs emptied, output register valid cleared, in-flight results lost, busy masks zeroed. Reset values: `regWrite`x=0, `destReg`x=0, `writeData`x=0, `busy`x=0, `exReady`x=0 and `issueReady`x=0 while reset low, both 1 from the first cycle after release.

## Timing
- Results are launched from posedge flops. The register file captures on negedge, so `regWrite`/`destReg`/`writeData` are stable half a cycle before capture.
- Latency, accept edge t, no stall: with bypass, `regWrite` high in cycle t..t+1, data in register file at that negedge, `busy` bit clears at edge t+1. Without bypass, everything shifts one cycle later.
- Throughput: one write per lane per cycle when unstalled. `exReady` drops when DEPTH entries are held.
- A `wbStall` pulse of N cycles delays all retires by N cycles; no entry is lost or duplicated.

## Configuration
- `DUAL_WB_BYPASS_EN` defined: on an accept edge with the FIFO empty and `wbStall`=0, the incoming result loads the output register directly, giving accept→`regWrite` latency of 1 cycle.
- Undefined: every result passes through the FIFO, giving a latency of 2 cycles. Ordering and scoreboard rules are identical either way.

## Structure
- `dual_wb_pkg` holds `DATA_W`, `REG_ADDR_W`, `NUM_REGS`=16 and the entry typedef `wb_entry_t` {dest, data}.
- `dual_wb_stage` instantiates two copies of the sub-module `wb_lane`, which contains the FIFO, the output register and the scoreboard. The top level only distributes `clk`, `reset` and `wbStall`.

## Test plan
- Reset low mid-stream with 2 entries queued in lane 1 → `regWrite1`=0, `busy1`=0, `exReady1`=0. After release: `exReady1`=1 and no stale write appears.
- Issue dest 5 on lane 1, then accept result 0xBEEF for dest 5 → `busy1`[5]=1, `issueReady1`=0 for dest 5; `regWrite1`=1/`destReg1`=5/`writeData1`=0xBEEF 1 cycle after accept (bypass build); `busy1`[5]=0 the next edge.
- Accept dest 0 with data 0x1234, and separately a result with `exWrEn`=0 → no `regWrite`, FIFO count unchanged.
- Hold `wbStall`=1 while accepting 3 results on lane 2 → third result blocked (`exReady2`=0 after 2). Release stall → writes to 3, 4, 5 retire in order on consecutive cycles.
- Same edge: retire dest 7 and issue new dest 7 on lane 1 → `busy1`[7] stays 1.
- Both lanes accept dest 3 (0x1111 on lane 1, 0x2222 on lane 2) on the same edge → each lane writes its own set; `busy1` and `busy2` are independent.

Source files
------------

// File: rtl/dual_wb_pkg.sv
// dual_wb_pkg: shared widths and the writeback entry type for dual_wb_stage.
package dual_wb_pkg;

  localparam int DATA_W     = 16;
  localparam int REG_ADDR_W = 4;
  localparam int NUM_REGS   = 16;

  // One buffered register write: destination index plus result value.
  typedef struct packed {
    logic [REG_ADDR_W-1:0] dest;
    logic [DATA_W-1:0]     data;
  } wb_entry_t;

endpackage

// File: rtl/wb_lane.sv
// wb_lane: one writeback lane -- result FIFO, registered register-file write
// port and a pending-write scoreboard for the issue stage.
// Optional feature macro: DUAL_WB_BYPASS_EN (empty FIFO + no stall lets an
// accepted result load the output register directly).
module wb_lane
  import dual_wb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wbStall,
  input  logic                  exValid,
  output logic                  exReady,
  input  logic                  exWrEn,
  input  logic [REG_ADDR_W-1:0] exDest,
  input  logic [DATA_W-1:0]     exData,
  input  logic                  issueValid,
  input  logic [REG_ADDR_W-1:0] issueDest,
  output logic                  issueReady,
  output logic [NUM_REGS-1:0]   busy,
  output logic                  regWrite,
  output logic [REG_ADDR_W-1:0] destReg,
  output logic [DATA_W-1:0]     writeData
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  wb_entry_t          mem [DEPTH];
  logic [PTR_W-1:0]   rdPtr;
  logic [PTR_W-1:0]   wrPtr;
  logic [CNT_W-1:0]   count;
  logic               fifoEmpty;
  logic               doEnq;
  logic               doPush;
  logic               doPop;
  logic               loadOut;
  wb_entry_t          outNext;
  logic [NUM_REGS-1:0] busyNext;

  // Ready looks only at the registered count, so a full FIFO stays not-ready
  // even on an edge where it pops.
  assign exReady    = reset && (count < CNT_W'(DEPTH));
  assign issueReady = reset && (!busy[issueDest] || (issueDest == '0));
  assign fifoEmpty  = (count == '0);
  // Writes to r0 and non-writing results are accepted but never enqueued.
  assign doEnq      = exValid && exReady && exWrEn && (exDest != '0);

  // Retire selection: FIFO head first, optional bypass when the FIFO is empty.
  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    doPush  = doEnq;
    doPop   = 1'b0;
    loadOut = 1'b0;
    outNext = mem[rdPtr];
    if (!wbStall) begin
      if (!fifoEmpty) begin
        doPop   = 1'b1;
        loadOut = 1'b1;
      end
`ifdef DUAL_WB_BYPASS_EN
      else if (doEnq) begin
        doPush  = 1'b0;
        loadOut = 1'b1;
        outNext = '{dest: exDest, data: exData};
      end
`endif
    end
  end

  // FIFO storage; contents are only meaningful below count.
  always_ff @(posedge clk) begin
    // NOTE: the storage array carries no reset; the pointers and count already mark it empty.
    if (doPush) mem[wrPtr] <= '{dest: exDest, data: exData};
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!reset) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + PTR_W'(1);
      if (doPop)  rdPtr <= rdPtr + PTR_W'(1);
      case ({doPush, doPop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Registered register-file write port; index and data hold while idle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      regWrite  <= 1'b0;
      destReg   <= '0;
      writeData <= '0;
    end else begin
      regWrite <= loadOut;
      if (loadOut) begin
        destReg   <= outNext.dest;
        writeData <= outNext.data;
      end
    end
  end

  // Scoreboard next state: clear on retire, then set on issue so set wins.
  always_comb begin
    busyNext = busy;
    if (regWrite) busyNext[destReg] = 1'b0;
    if (issueValid && issueReady && (issueDest != '0)) busyNext[issueDest] = 1'b1;
    busyNext[0] = 1'b0;
  end

  // Scoreboard register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) busy <= '0;
    else        busy <= busyNext;
  end

endmodule

// File: rtl/dual_wb_stage.sv
// dual_wb_stage: two independent writeback lanes feeding register sets 1 and 2.
// Optional feature macro: DUAL_WB_BYPASS_EN (see wb_lane).
module dual_wb_stage #(
  parameter int DATA_W     = dual_wb_pkg::DATA_W,
  parameter int REG_ADDR_W = dual_wb_pkg::REG_ADDR_W,
  parameter int DEPTH      = 2
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            wbStall,
  input  logic                            exValid1,
  output logic                            exReady1,
  input  logic                            exWrEn1,
  input  logic [REG_ADDR_W-1:0]           exDest1,
  input  logic [DATA_W-1:0]               exData1,
  input  logic                            issueValid1,
  input  logic [REG_ADDR_W-1:0]           issueDest1,
  output logic                            issueReady1,
  output logic [dual_wb_pkg::NUM_REGS-1:0] busy1,
  output logic                            regWrite1,
  output logic [REG_ADDR_W-1:0]           destReg1,
  output logic [DATA_W-1:0]               writeData1,
  input  logic                            exValid2,
  output logic                            exReady2,
  input  logic                            exWrEn2,
  input  logic [REG_ADDR_W-1:0]           exDest2,
  input  logic [DATA_W-1:0]               exData2,
  input  logic                            issueValid2,
  input  logic [REG_ADDR_W-1:0]           issueDest2,
  output logic                            issueReady2,
  output logic [dual_wb_pkg::NUM_REGS-1:0] busy2,
  output logic                            regWrite2,
  output logic [REG_ADDR_W-1:0]           destReg2,
  output logic [DATA_W-1:0]               writeData2
);

  wb_lane #(.DEPTH(DEPTH)) lane1 (
    .clk        (clk),
    .reset      (reset),
    .wbStall    (wbStall),
    .exValid    (exValid1),
    .exReady    (exReady1),
    .exWrEn     (exWrEn1),
    .exDest     (exDest1),
    .exData     (exData1),
    .issueValid (issueValid1),
    .issueDest  (issueDest1),
    .issueReady (issueReady1),
    .busy       (busy1),
    .regWrite   (regWrite1),
    .destReg    (destReg1),
    .writeData  (writeData1)
  );

  wb_lane #(.DEPTH(DEPTH)) lane2 (
    .clk        (clk),
    .reset      (reset),
    .wbStall    (wbStall),
    .exValid    (exValid2),
    .exReady    (exReady2),
    .exWrEn     (exWrEn2),
    .exDest     (exDest2),
    .exData     (exData2),
    .issueValid (issueValid2),
    .issueDest  (issueDest2),
    .issueReady (issueReady2),
    .busy       (busy2),
    .regWrite   (regWrite2),
    .destReg    (destReg2),
    .writeData  (writeData2)
  );

endmodule

// File: tb/tb_dual_wb_stage.sv
// tb_dual_wb_stage: directed test-plan steps plus a random phase, all checked
// against a queue-based behavioural model of both lanes.
module tb_dual_wb_stage;

  localparam int DW    = 16;
  localparam int AW    = 4;
  localparam int DEPTH = 2;
`ifdef DUAL_WB_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif
  localparam int LAT = BYPASS ? 1 : 2;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          wbStall = 1'b0;
  logic [1:0]    exValid = '0;
  logic [1:0]    exWrEn = '0;
  logic [1:0]    issueValid = '0;
  logic [AW-1:0] exDest [2];
  logic [AW-1:0] issueDest [2];
  logic [DW-1:0] exData [2];

  logic          exReady1, exReady2, issueReady1, issueReady2, regWrite1, regWrite2;
  logic [15:0]   busy1, busy2;
  logic [AW-1:0] destReg1, destReg2;
  logic [DW-1:0] writeData1, writeData2;

  logic [1:0]    oExReady, oIssueReady, oRegWrite;
  logic [15:0]   oBusy [2];
  logic [AW-1:0] oDest [2];
  logic [DW-1:0] oData [2];

  assign oExReady    = {exReady2, exReady1};
  assign oIssueReady = {issueReady2, issueReady1};
  assign oRegWrite   = {regWrite2, regWrite1};
  assign oBusy[0] = busy1;
  assign oBusy[1] = busy2;
  assign oDest[0] = destReg1;
  assign oDest[1] = destReg2;
  assign oData[0] = writeData1;
  assign oData[1] = writeData2;

  always #5 clk = ~clk;

  dual_wb_stage #(.DATA_W(DW), .REG_ADDR_W(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .wbStall(wbStall),
    .exValid1(exValid[0]), .exReady1(exReady1), .exWrEn1(exWrEn[0]),
    .exDest1(exDest[0]), .exData1(exData[0]),
    .issueValid1(issueValid[0]), .issueDest1(issueDest[0]), .issueReady1(issueReady1),
    .busy1(busy1), .regWrite1(regWrite1), .destReg1(destReg1), .writeData1(writeData1),
    .exValid2(exValid[1]), .exReady2(exReady2), .exWrEn2(exWrEn[1]),
    .exDest2(exDest[1]), .exData2(exData[1]),
    .issueValid2(issueValid[1]), .issueDest2(issueDest[1]), .issueReady2(issueReady2),
    .busy2(busy2), .regWrite2(regWrite2), .destReg2(destReg2), .writeData2(writeData2)
  );

  // ---------------- behavioural model ----------------
  typedef struct { int dest; int data; } ent_t;
  ent_t      mq [2][$];
  bit        mRst;
  bit        mRw [2];
  int        mDest [2];
  int        mData [2];
  bit [15:0] mBusy [2];

  int errors = 0;
  int checks = 0;

  function automatic bit mExReady(int l);
    return mRst && (mq[l].size() < DEPTH);
  endfunction

  function automatic bit mIssueReady(int l);
    return mRst && ((issueDest[l] == 0) || !mBusy[l][issueDest[l]]);
  endfunction

  task automatic modelReset();
    mRst = 1'b0;
    for (int l = 0; l < 2; l++) begin
      mq[l].delete();
      mRw[l] = 1'b0; mDest[l] = 0; mData[l] = 0; mBusy[l] = '0;
    end
  endtask

  // Applies one clock edge using the inputs present before it.
  task automatic modelEdge();
    bit        enq, iss;
    bit [15:0] b;
    ent_t      e;
    if (!mRst) return;
    for (int l = 0; l < 2; l++) begin
      enq = exValid[l] && mExReady(l) && exWrEn[l] && (exDest[l] != 0);
      iss = issueValid[l] && mIssueReady(l) && (issueDest[l] != 0);
      b = mBusy[l];
      if (mRw[l]) b[mDest[l]] = 1'b0;
      if (iss) b[issueDest[l]] = 1'b1;
      b[0] = 1'b0;
      mRw[l] = 1'b0;
      if (!wbStall) begin
        if (mq[l].size() > 0) begin
          e = mq[l].pop_front();
          mRw[l] = 1'b1; mDest[l] = e.dest; mData[l] = e.data;
        end else if (BYPASS && enq) begin
          mRw[l] = 1'b1; mDest[l] = int'(exDest[l]); mData[l] = int'(exData[l]);
          enq = 1'b0;
        end
      end
      if (enq) mq[l].push_back('{int'(exDest[l]), int'(exData[l])});
      mBusy[l] = b;
    end
  endtask

  // ---------------- checking ----------------
  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkComb();
    for (int l = 0; l < 2; l++) begin
      check($sformatf("exReady%0d", l + 1), 32'(oExReady[l]), 32'(mExReady(l)));
      check($sformatf("issueReady%0d", l + 1), 32'(oIssueReady[l]), 32'(mIssueReady(l)));
    end
  endtask

  task automatic checkRegs();
    for (int l = 0; l < 2; l++) begin
      check($sformatf("regWrite%0d", l + 1), 32'(oRegWrite[l]), 32'(mRw[l]));
      check($sformatf("destReg%0d", l + 1), 32'(oDest[l]), mDest[l]);
      check($sformatf("writeData%0d", l + 1), 32'(oData[l]), mData[l]);
      check($sformatf("busy%0d", l + 1), 32'(oBusy[l]), 32'(mBusy[l]));
    end
  endtask

  // Inputs are set by the caller away from the edge; checks straddle one posedge.
  task automatic tick();
    #1 checkComb();
    @(posedge clk);
    modelEdge();
    #1 checkRegs();
  endtask

  task automatic idle();
    wbStall = 1'b0; exValid = '0; exWrEn = '0; issueValid = '0;
    for (int l = 0; l < 2; l++) begin
      exDest[l] = '0; exData[l] = '0; issueDest[l] = '0;
    end
  endtask

  initial begin
    idle();
    modelReset();
    // Reset state.
    #1 checkComb();
    checkRegs();
    check("rst_exReady1", 32'(exReady1), 0);
    check("rst_issueReady2", 32'(issueReady2), 0);
    @(negedge clk);
    reset = 1'b1; mRst = 1'b1;
    tick();
    check("post_rst_exReady1", 32'(exReady1), 1);

    // Mid-stream reset with two entries queued in lane 1 behind a stall.
    wbStall = 1'b1;
    exValid[0] = 1'b1; exWrEn[0] = 1'b1; exDest[0] = 4'd1; exData[0] = 16'hA001;
    issueValid[0] = 1'b1; issueDest[0] = 4'd9;
    tick();
    issueValid[0] = 1'b0;
    exDest[0] = 4'd2; exData[0] = 16'hA002;
    tick();
    reset = 1'b0;
    modelReset();
    #1 check("midrst_regWrite1", 32'(regWrite1), 0);
    check("midrst_busy1", 32'(busy1), 0);
    check("midrst_exReady1", 32'(exReady1), 0);
    @(posedge clk);
    #1 checkComb();
    checkRegs();
    @(negedge clk);
    idle();
    reset = 1'b1; mRst = 1'b1;
    #1 check("rel_exReady1", 32'(exReady1), 1);
    repeat (3) tick();

    // Issue dest 5, then its result 0xBEEF.
    issueValid[0] = 1'b1; issueDest[0] = 4'd5;
    tick();
    issueValid[0] = 1'b0;
    check("busy1_5_set", 32'(busy1[5]), 1);
    #1 check("issueReady1_d5", 32'(issueReady1), 0);
    exValid[0] = 1'b1; exWrEn[0] = 1'b1; exDest[0] = 4'd5; exData[0] = 16'hBEEF;
    tick();
    exValid[0] = 1'b0;
    repeat (LAT - 1) tick();
    check("beef_regWrite1", 32'(regWrite1), 1);
    check("beef_destReg1", 32'(destReg1), 5);
    check("beef_writeData1", 32'(writeData1), 32'h0000BEEF);
    tick();
    check("busy1_5_clr", 32'(busy1[5]), 0);

    // Writes to r0 and non-writing results are discarded.
    exValid[0] = 1'b1; exWrEn[0] = 1'b1; exDest[0] = 4'd0; exData[0] = 16'h1234;
    tick();
    exWrEn[0] = 1'b0; exDest[0] = 4'd6; exData[0] = 16'h5555;
    tick();
    idle();
    for (int i = 0; i < 3; i++) begin
      tick();
      check("discard_regWrite1", 32'(regWrite1), 0);
    end

    // Lane 2: stall while filling, third result blocked, ordered retire.
    wbStall = 1'b1;
    exValid[1] = 1'b1; exWrEn[1] = 1'b1; exDest[1] = 4'd3; exData[1] = 16'h0C03;
    tick();
    exDest[1] = 4'd4; exData[1] = 16'h0C04;
    tick();
    check("full_exReady2", 32'(exReady2), 0);
    exDest[1] = 4'd5; exData[1] = 16'h0C05;
    tick();
    check("stall_regWrite2", 32'(regWrite2), 0);
    wbStall = 1'b0;
    tick();
    check("order_w0", 32'(regWrite2), 1);
    check("order_d0", 32'(destReg2), 3);
    tick();
    exValid[1] = 1'b0;
    check("order_d1", 32'(destReg2), 4);
    tick();
    check("order_w2", 32'(regWrite2), 1);
    check("order_d2", 32'(destReg2), 5);
    check("order_data2", 32'(writeData2), 32'h00000C05);
    idle();
    tick();

    // Retire dest 7 and issue dest 7 on the same edge: set wins.
    exValid[0] = 1'b1; exWrEn[0] = 1'b1; exDest[0] = 4'd7; exData[0] = 16'h7777;
    tick();
    exValid[0] = 1'b0;
    repeat (LAT - 1) tick();
    check("ret7_regWrite1", 32'(regWrite1), 1);
    issueValid[0] = 1'b1; issueDest[0] = 4'd7;
    tick();
    issueValid[0] = 1'b0;
    check("setwins_busy1_7", 32'(busy1[7]), 1);

    // Both lanes write dest 3 on the same edge; scoreboards are independent.
    issueValid[0] = 1'b1; issueDest[0] = 4'd3;
    tick();
    issueValid[0] = 1'b0;
    exValid = 2'b11; exWrEn = 2'b11;
    exDest[0] = 4'd3; exData[0] = 16'h1111;
    exDest[1] = 4'd3; exData[1] = 16'h2222;
    tick();
    exValid = '0;
    repeat (LAT - 1) tick();
    check("dual_data1", 32'(writeData1), 32'h1111);
    check("dual_data2", 32'(writeData2), 32'h2222);
    check("dual_busy1_3", 32'(busy1[3]), 1);
    check("dual_busy2_3", 32'(busy2[3]), 0);
    tick();
    check("dual_busy1_3_clr", 32'(busy1[3]), 0);

    // Random phase with one asynchronous reset pulse.
    for (int c = 0; c < 600; c++) begin
      if (c == 300) begin
        #2 reset = 1'b0;
        modelReset();
        #1 checkComb();
        checkRegs();
        #1 reset = 1'b1;
        mRst = 1'b1;
      end
      wbStall = ($urandom_range(3) == 0);
      for (int l = 0; l < 2; l++) begin
        exValid[l]    = $urandom_range(1);
        exWrEn[l]     = ($urandom_range(7) != 0);
        exDest[l]     = AW'($urandom_range(15));
        exData[l]     = DW'($urandom);
        issueValid[l] = $urandom_range(1);
        issueDest[l]  = AW'($urandom_range(15));
      end
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
